// File: rtl/updn_pkg.sv
// Shared constants for the up/down counter: mode encodings and default width.
package updn_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam int unsigned GRAY_OFF = 0;
    localparam int unsigned GRAY_ON  = 1;

    localparam int unsigned SAT_WRAP = 0;
    localparam int unsigned SAT_HOLD = 1;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

endpackage

// File: rtl/updn_counter_bin2gray.sv
// Combinational binary-to-Gray encoder.
module bin2gray #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray_c
);

    assign gray_c = bin ^ (bin >> 1);

endmodule

// File: rtl/updn_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with load, wrap or saturate, optional
// Gray output, a terminal-count pulse and a sticky boundary flag.
module updn_counter
    import updn_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned MAX_VAL  = 32'((64'(1) << WIDTH) - 64'(1)),
    parameter int unsigned GRAY     = GRAY_OFF,
    parameter int unsigned SATURATE = SAT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bin,
    output logic             tc,
    output logic             ovf
);

    localparam longint unsigned FULL_SCALE = (64'(1) << WIDTH) - 64'(1);
    localparam logic [WIDTH-1:0] MAXV      = WIDTH'(MAX_VAL);

    // Elaboration-time parameter legality check.
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("updn_counter: WIDTH=%0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
    end
    if (MAX_VAL == 0 || 64'(MAX_VAL) > FULL_SCALE) begin : g_bad_max
        $error("updn_counter: MAX_VAL=%0d outside 1..2**WIDTH-1", MAX_VAL);
    end

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             tc_next;
    logic             ovf_next;
    logic             at_top;
    logic             at_bottom;

    assign at_top    = (count_bin >= MAXV);
    assign at_bottom = (count_bin == '0);

    // Next-state: load beats enable; a boundary step wraps or holds and flags.
    always_comb begin
        bin_next = count_bin;
        tc_next  = 1'b0;
        ovf_next = ovf;
        if (load) begin
            bin_next = (load_val > MAXV) ? MAXV : load_val;
            ovf_next = 1'b0;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    bin_next = (SATURATE == SAT_HOLD) ? MAXV : '0;
                    tc_next  = 1'b1;
                    ovf_next = 1'b1;
                end else begin
                    bin_next = count_bin + WIDTH'(1);
                end
            end else begin
                if (at_bottom) begin
                    bin_next = (SATURATE == SAT_HOLD) ? '0 : MAXV;
                    tc_next  = 1'b1;
                    ovf_next = 1'b1;
                end else begin
                    bin_next = count_bin - WIDTH'(1);
                end
            end
        end
    end

    // Gray code is taken from the next value so count and count_bin align.
    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin    (bin_next),
        .gray_c (gray_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_bin <= '0;
            count     <= '0;
            tc        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            count_bin <= bin_next;
            count     <= (GRAY == GRAY_ON) ? gray_next : bin_next;
            tc        <= tc_next;
            ovf       <= ovf_next;
        end
    end

endmodule

// File: tb/tb_updn_counter.sv
// Randomised and directed bench for updn_counter across three configurations,
// checked against an arithmetic reference model.
module tb_updn_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] cnt  [3];
    logic [3:0] cbin [3];
    logic       tcs  [3];
    logic       ovfs [3];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Per-instance configuration and model state.
    int mmax  [3] = '{15, 9, 15};
    bit msat  [3] = '{1'b0, 1'b0, 1'b1};
    bit mgray [3] = '{1'b1, 1'b0, 1'b0};
    int mb    [3];
    bit mtc   [3];
    bit movf  [3];

    logic [3:0] gseq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    always #5 clk = ~clk;

    updn_counter #(.WIDTH(4), .GRAY(1), .SATURATE(0)) d_gray (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(cnt[0]), .count_bin(cbin[0]), .tc(tcs[0]), .ovf(ovfs[0]));

    updn_counter #(.WIDTH(4), .MAX_VAL(9), .GRAY(0), .SATURATE(0)) d_mod10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(cnt[1]), .count_bin(cbin[1]), .tc(tcs[1]), .ovf(ovfs[1]));

    updn_counter #(.WIDTH(4), .GRAY(0), .SATURATE(1)) d_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(cnt[2]), .count_bin(cbin[2]), .tc(tcs[2]), .ovf(ovfs[2]));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference behaviour: a modulus-(max+1) ring, stepping off either end is a boundary event.
    task automatic model_step(input int i);
        int raw;
        mtc[i] = 1'b0;
        if (rst) begin
            mb[i] = 0;
            movf[i] = 1'b0;
        end else if (load) begin
            mb[i] = (int'(load_val) > mmax[i]) ? mmax[i] : int'(load_val);
            movf[i] = 1'b0;
        end else if (en) begin
            raw = up ? mb[i] + 1 : mb[i] - 1;
            if (raw > mmax[i] || raw < 0) begin
                mtc[i] = 1'b1;
                movf[i] = 1'b1;
                if (msat[i])
                    mb[i] = (raw < 0) ? 0 : mmax[i];
                else
                    mb[i] = ((raw % (mmax[i] + 1)) + (mmax[i] + 1)) % (mmax[i] + 1);
            end else begin
                mb[i] = raw;
            end
        end
    endtask

    task automatic check_all();
        int e;
        for (int i = 0; i < 3; i++) begin
            e = mgray[i] ? (mb[i] ^ (mb[i] >> 1)) : mb[i];
            check($sformatf("d%0d.count", i),     32'(cnt[i]),  32'(e));
            check($sformatf("d%0d.count_bin", i), 32'(cbin[i]), 32'(mb[i]));
            check($sformatf("d%0d.tc", i),        32'(tcs[i]),  32'(mtc[i]));
            check($sformatf("d%0d.ovf", i),       32'(ovfs[i]), 32'(movf[i]));
        end
    endtask

    // One clock: drive inputs, advance model on the edge, sample just after.
    task automatic cyc(input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        check_all();
    endtask

    initial begin
        // Reset dominates load and enable.
        cyc(1, 1, 1, 1, 4'd7);
        cyc(1, 1, 1, 1, 4'd7);
        check("rst.count",  32'(cnt[0]),  32'd0);
        check("rst.bin",    32'(cbin[1]), 32'd0);
        check("rst.ovf",    32'(ovfs[2]), 32'd0);

        // Full Gray up-sequence on the 4-bit wrapping instance.
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 1, 1, 0, 4'd0);
            check($sformatf("gray_seq[%0d]", k), 32'(cnt[0]), 32'(gseq[k]));
            check($sformatf("gray_tc[%0d]", k),  32'(tcs[0]), (k == 16) ? 32'd1 : 32'd0);
        end
        check("gray_ovf", 32'(ovfs[0]), 32'd1);

        // Mod-10 wrap in both directions.
        cyc(0, 0, 1, 1, 4'd8);
        cyc(0, 1, 1, 0, 4'd0);
        check("mod10.9",    32'(cbin[1]), 32'd9);
        cyc(0, 1, 1, 0, 4'd0);
        check("mod10.wrap", 32'(cbin[1]), 32'd0);
        check("mod10.tc",   32'(tcs[1]),  32'd1);
        cyc(0, 1, 0, 0, 4'd0);
        check("mod10.down", 32'(cbin[1]), 32'd9);
        check("mod10.tc2",  32'(tcs[1]),  32'd1);

        // Saturation holds at 15 with a tc every boundary cycle.
        cyc(0, 0, 1, 1, 4'd15);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 0, 4'd0);
            check("sat.hold", 32'(cbin[2]), 32'd15);
            check("sat.tc",   32'(tcs[2]),  32'd1);
        end
        check("sat.ovf", 32'(ovfs[2]), 32'd1);
        cyc(0, 0, 1, 1, 4'd3);
        check("sat.load",    32'(cbin[2]), 32'd3);
        check("sat.ovf_clr", 32'(ovfs[2]), 32'd0);

        // Load clamps and beats enable; reset beats load.
        cyc(0, 1, 1, 1, 4'd12);
        check("prio.clamp", 32'(cbin[1]), 32'd9);
        cyc(1, 1, 1, 1, 4'd12);
        check("prio.rst", 32'(cbin[1]), 32'd0);

        // Direction change takes effect on the same edge; en=0 holds.
        cyc(0, 0, 1, 1, 4'd4);
        cyc(0, 1, 1, 0, 4'd0);
        cyc(0, 1, 1, 0, 4'd0);
        check("dir.6", 32'(cbin[0]), 32'd6);
        cyc(0, 1, 0, 0, 4'd0);
        check("dir.5", 32'(cbin[0]), 32'd5);
        cyc(0, 1, 0, 0, 4'd0);
        check("dir.4", 32'(cbin[0]), 32'd4);
        cyc(0, 0, 1, 0, 4'd0);
        check("dir.hold", 32'(cbin[0]), 32'd4);
        check("dir.tc",   32'(tcs[0]),  32'd0);

        // Randomised traffic, biased toward enabled counting.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0),
                4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
